rpg_pattern_gen: RTL and testbench
==================================

// Module: rpg_pattern_gen
// PURPOSE
//  Reference pattern generator upstream of the lock-step error counter. Drives serial test data
//  into the DUT shift-register chain (DATA_OUT) and a delay-matched reference copy (RPG_OUT) into
//  the counter's RPG input. Modes: constant, checkerboard, PRBS7, PRBS15. Bursts run either for a
//  programmed length or continuously.
// PARAMETERS
//  PRE_LEN  16  zero bits emitted before the pattern; the checker aligns on the first rising edge
//  MAX_DLY  64  depth of the reference delay line, in CLK cycles (>=1)
//  DLY_W    7   width of DLY; must satisfy 2**DLY_W > MAX_DLY
// PORTS
//  CLK        in   1      single clock domain
//  RST_PER_N  in   1      asynchronous reset, active low
//  START      in   1      one-cycle pulse; starts a burst when IDLE
//  STOP       in   1      one-cycle pulse; aborts the burst in progress
//  MODE       in   3      0 all-0, 1 all-1, 2 checkerboard, 3 PRBS7, 4 PRBS15, 5-7 = all-0
//  LEN        in   32     number of pattern bits in RUN; 0 = continuous until STOP
//  DLY        in   DLY_W  RPG_OUT lag behind DATA_OUT, in cycles
//  DATA_OUT   out  1      serial data to the DUT chain (registered)
//  RPG_OUT    out  1      DATA_OUT delayed by DLY cycles
//  BUSY       out  1      high in PREAMBLE and RUN
//  DONE       out  1      one-cycle pulse at burst end (normal completion or STOP)
//  BIT_CNT    out  32     pattern bits emitted in the current/last burst
// BEHAVIOUR
//  Reset: state=IDLE; DATA_OUT, RPG_OUT, BUSY, DONE = 0; BIT_CNT = 0; delay line cleared; LFSRs seeded.
//  FSM IDLE -> PREAMBLE -> RUN -> IDLE (DONE pulses on the cycle the FSM returns to IDLE).
//   IDLE: DATA_OUT=0. On START=1 and STOP=0: latch MODE/LEN/DLY, clear BIT_CNT, enter PREAMBLE.
//     START while BUSY is ignored. START together with STOP in IDLE is ignored (STOP wins).
//   PREAMBLE: DATA_OUT=0 for exactly PRE_LEN cycles, then enter RUN.
//   RUN: one pattern bit per cycle; BIT_CNT increments per bit, saturating at 2^32-1.
//     LEN!=0: after LEN bits, go to IDLE with DONE=1. LEN=0: run until STOP.
//   STOP in PREAMBLE/RUN: DATA_OUT=0 on the next cycle, FSM goes to IDLE, DONE=1, BIT_CNT holds.
//  Timing: START sampled at edge n gives the first preamble bit at n+1, the first pattern bit at
//   n+1+PRE_LEN, the last at n+PRE_LEN+LEN, and DONE with DATA_OUT=0 at n+PRE_LEN+LEN+1.
//  Patterns (the first RUN bit is 1 for modes 1-4 so the checker can lock):
//   mode 2: 1,0,1,0,...
//   mode 3: Fibonacci LFSR x^7+x^6+1, seed 7'h7F, output = MSB, shift after each bit; period 127
//   mode 4: Fibonacci LFSR x^15+x^14+1, seed 15'h7FFF, same output rule; period 32767
//   Generators re-seed at every START, so bursts are repeatable.
//  Delay line: shifts every cycle, including IDLE, so the last bits flush out to RPG_OUT.
//   RPG_OUT = DATA_OUT from DLY cycles earlier. DLY=0 means RPG_OUT == DATA_OUT combinationally.
//   DLY > MAX_DLY clamps to MAX_DLY. The latched DLY is used for the whole burst.
//  MODE/LEN/DLY changes while BUSY have no effect until the next START.
//  Async reset mid-burst: immediate return to reset values; no DONE pulse.
// TESTING
//  T1 MODE=3, LEN=254, DLY=0 -> 16 zeros, then PRBS7 twice (127-bit period check), DONE at
//     n+271, BIT_CNT=254.
//  T2 MODE=2, LEN=8, DLY=5 -> DATA_OUT 1010_1010; RPG_OUT same sequence 5 cycles later, then 0.
//  T3 MODE=4, LEN=0, STOP after 1000 RUN bits -> DATA_OUT=0 next cycle, DONE=1, BIT_CNT=1000;
//     the first 15 bits are all 1.
//  T4 START+STOP same cycle in IDLE -> stays IDLE, BUSY=0, no DONE.
//     START mid-RUN -> ignored, BIT_CNT continuous.
//  T5 DLY=100 with MAX_DLY=64 -> RPG_OUT lags by 64. MODE=6 -> all zeros for LEN bits, DONE normal.
//  T6 RST_PER_N low mid-RUN -> all outputs 0 asynchronously. A new START then reproduces T1 bit-exact.

Source files
------------

// File: rtl/rpg_pattern_gen_if.sv
// Control and observation bundle of the reference pattern generator.
// The master drives burst requests; the slave is the generator itself.
interface rpg_pattern_gen_if #(
  parameter int unsigned DlyW = 7
) ();
  logic            start;
  logic            stop;
  logic [2:0]      mode;
  logic [31:0]     len;
  logic [DlyW-1:0] dly;
  logic            data_out;
  logic            rpg_out;
  logic            busy;
  logic            done;
  logic [31:0]     bit_cnt;

  modport master (
    output start, stop, mode, len, dly,
    input  data_out, rpg_out, busy, done, bit_cnt
  );

  modport slave (
    input  start, stop, mode, len, dly,
    output data_out, rpg_out, busy, done, bit_cnt
  );
endinterface

// File: rtl/rpg_pattern_gen.sv
// Serial test-pattern source: zero preamble, then constant/checkerboard/PRBS bits,
// with a delay-matched reference copy for the downstream error counter.
module rpg_pattern_gen #(
  parameter int unsigned PreLen = 16,
  parameter int unsigned MaxDly = 64,
  parameter int unsigned DlyW   = 7
) (
  input logic              clk,
  input logic              rst_per_n,
  rpg_pattern_gen_if.slave bus
);
  localparam int unsigned PreW = (PreLen > 1) ? $clog2(PreLen) : 1;

  typedef enum logic [1:0] {StIdle, StPre, StRun} state_e;

  state_e          state_q, state_d;
  logic [2:0]      mode_q;
  logic [31:0]     len_q, bit_cnt_q;
  logic [DlyW-1:0] dly_q, dly_clamp;
  logic [PreW-1:0] pre_cnt_q;
  logic [6:0]      prbs7_q;
  logic [14:0]     prbs15_q;
  logic            chk_q;
  logic            data_q, done_q;
  logic [MaxDly:1] dline_q;
  logic [MaxDly:0] taps;
  logic            launch, last, emit, pat_bit, data_d, done_d;

  assign dly_clamp = (bus.dly > DlyW'(MaxDly)) ? DlyW'(MaxDly) : bus.dly;
  // A finite burst spends one extra RUN cycle after its last bit to drop data and flag DONE.
  assign last      = (len_q != '0) && (bit_cnt_q == len_q);

  always_ff @(posedge clk or negedge rst_per_n) begin
    if (!rst_per_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start && !bus.stop) state_d = StPre;
      StPre: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else if (pre_cnt_q == PreW'(PreLen - 1)) begin
          state_d = StRun;
        end
      end
      StRun:   if (bus.stop || last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != StIdle);
    launch   = (state_q == StIdle) && bus.start && !bus.stop;
    emit     = (state_q == StRun) && !bus.stop && !last;
    done_d   = (state_q != StIdle) && (state_d == StIdle);
    unique case (mode_q)
      3'd1:    pat_bit = 1'b1;
      3'd2:    pat_bit = chk_q;
      3'd3:    pat_bit = prbs7_q[6];
      3'd4:    pat_bit = prbs15_q[14];
      default: pat_bit = 1'b0;
    endcase
    data_d = emit & pat_bit;
  end

  always_ff @(posedge clk or negedge rst_per_n) begin
    if (!rst_per_n) begin
      mode_q    <= '0;
      len_q     <= '0;
      dly_q     <= '0;
      bit_cnt_q <= '0;
      pre_cnt_q <= '0;
      prbs7_q   <= '1;
      prbs15_q  <= '1;
      chk_q     <= 1'b1;
      data_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      data_q <= data_d;
      done_q <= done_d;
      if (launch) begin
        mode_q    <= bus.mode;
        len_q     <= bus.len;
        dly_q     <= dly_clamp;
        bit_cnt_q <= '0;
        pre_cnt_q <= '0;
        prbs7_q   <= '1;
        prbs15_q  <= '1;
        chk_q     <= 1'b1;
      end else begin
        if (state_q == StPre) pre_cnt_q <= pre_cnt_q + PreW'(1);
        if (emit) begin
          if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + 32'd1;
          prbs7_q  <= {prbs7_q[5:0], prbs7_q[6] ^ prbs7_q[5]};
          prbs15_q <= {prbs15_q[13:0], prbs15_q[14] ^ prbs15_q[13]};
          chk_q    <= ~chk_q;
        end
      end
    end
  end

  // The delay line runs in every state so the tail of a burst still reaches rpg_out.
  always_ff @(posedge clk or negedge rst_per_n) begin
    if (!rst_per_n) begin
      dline_q <= '0;
    end else begin
      dline_q[1] <= data_q;
      for (int i = 2; i <= MaxDly; i++) dline_q[i] <= dline_q[i-1];
    end
  end

  assign taps         = {dline_q, data_q};
  assign bus.rpg_out  = taps[dly_q];
  assign bus.data_out = data_q;
  assign bus.done     = done_q;
  assign bus.bit_cnt  = bit_cnt_q;
endmodule

// File: tb/tb_rpg_pattern_gen.sv
// Bench for rpg_pattern_gen: burst-timeline model checked every cycle, plus directed
// scenarios with hand-computed latencies, counts and bit patterns.
module tb_rpg_pattern_gen;
  localparam int unsigned PreLen = 16;
  localparam int unsigned MaxDly = 64;
  localparam int unsigned DlyW   = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  rpg_pattern_gen_if #(.DlyW(DlyW)) bus ();

  rpg_pattern_gen #(
    .PreLen(PreLen),
    .MaxDly(MaxDly),
    .DlyW  (DlyW)
  ) dut (
    .clk      (clk),
    .rst_per_n(rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // PRBS output sequences from their recurrences: s[t+N] = s[t] ^ s[t+1], first N bits 1.
  bit prbs7[127];
  bit prbs15[32767];

  function automatic bit pat(input bit [2:0] md, input int idx);
    case (md)
      3'd1:    return 1'b1;
      3'd2:    return (idx % 2) == 0;
      3'd3:    return prbs7[idx % 127];
      3'd4:    return prbs15[idx % 32767];
      default: return 1'b0;
    endcase
  endfunction

  // Model: count edges since START; bits 1..PreLen are preamble, then pattern index k-PreLen-1.
  bit          m_busy = 0, m_done = 0, m_data = 0;
  int          m_k = 0, m_idx = 0, m_dly = 0;
  int unsigned m_len = 0, m_cnt = 0;
  bit [2:0]    m_mode = 0;
  bit          hist[MaxDly+1];

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_data = 0; m_cnt = 0; m_dly = 0;
      foreach (hist[j]) hist[j] = 0;
    end else begin
      m_data = 0;
      m_done = 0;
      if (!m_busy) begin
        if (bus.start && !bus.stop) begin
          m_busy = 1; m_k = 0; m_cnt = 0;
          m_mode = bus.mode; m_len = bus.len;
          m_dly  = (int'(bus.dly) > int'(MaxDly)) ? int'(MaxDly) : int'(bus.dly);
        end
      end else if (bus.stop) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_k++;
        if (m_k > int'(PreLen)) begin
          m_idx = m_k - int'(PreLen) - 1;
          if (m_len != 0 && m_idx == int'(m_len)) begin
            m_busy = 0; m_done = 1;
          end else begin
            m_data = pat(m_mode, m_idx);
            m_cnt  = m_idx + 1;
          end
        end
      end
      for (int j = MaxDly; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = m_data;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("data_out", bus.data_out, m_data);
      chk("rpg_out", bus.rpg_out, hist[m_dly]);
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("bit_cnt", bus.bit_cnt, m_cnt);
    end
  end

  bit dat_log[1200];
  bit rpg_log[1200];
  int done_cyc, ones;

  task automatic cfg(input bit [2:0] md, input int unsigned ln, input int unsigned dl);
    bus.mode = md;
    bus.len  = ln;
    bus.dly  = DlyW'(dl);
  endtask

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Sample #1 after each of the next ncyc edges; cycle c is edge n+c after the START edge n.
  task automatic run_burst(input int ncyc);
    done_cyc = -1;
    ones     = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      #1;
      dat_log[c] = bus.data_out;
      rpg_log[c] = bus.rpg_out;
      ones += int'(bus.data_out);
      if (bus.done && done_cyc < 0) done_cyc = c;
    end
  endtask

  initial begin
    int          cnt;
    logic [7:0]  d8, r8;

    for (int i = 0; i < 7; i++) prbs7[i] = 1'b1;
    for (int i = 7; i < 127; i++) prbs7[i] = prbs7[i-7] ^ prbs7[i-6];
    for (int i = 0; i < 15; i++) prbs15[i] = 1'b1;
    for (int i = 15; i < 32767; i++) prbs15[i] = prbs15[i-15] ^ prbs15[i-14];

    bus.start = 1'b0;
    bus.stop  = 1'b0;
    cfg(3'd0, 0, 0);

    // Model pins against hand-derived values.
    chk("pin_prbs7_7", prbs7[7], 0);
    chk("pin_prbs7_13", prbs7[13], 1);
    chk("pin_prbs15_15", prbs15[15], 0);
    chk("pin_prbs15_29", prbs15[29], 1);
    cnt = 0;
    for (int i = 0; i < 127; i++) cnt += int'(prbs7[i]);
    chk("pin_prbs7_ones", cnt, 64);

    #1;
    chk("rst_data", bus.data_out, 0);
    chk("rst_rpg", bus.rpg_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cnt", bus.bit_cnt, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // T1: PRBS7, two periods, no delay.
    cfg(3'd3, 254, 0);
    pulse_start();
    run_burst(280);
    chk("t1_done_cyc", done_cyc, 271);
    chk("t1_ones", ones, 128);
    chk("t1_first_bit", dat_log[17], 1);
    chk("t1_last_pre", dat_log[16], 0);
    chk("t1_cnt", bus.bit_cnt, 254);

    // T2: checkerboard with 5-cycle reference lag.
    cfg(3'd2, 8, 5);
    pulse_start();
    run_burst(35);
    d8 = '0;
    r8 = '0;
    for (int i = 0; i < 8; i++) begin
      d8 = {d8[6:0], dat_log[17+i]};
      r8 = {r8[6:0], rpg_log[22+i]};
    end
    chk("t2_data", d8, 8'hAA);
    chk("t2_rpg", r8, 8'hAA);
    chk("t2_rpg_before", rpg_log[21], 0);
    chk("t2_rpg_after", rpg_log[30], 0);
    chk("t2_done_cyc", done_cyc, 25);
    chk("t2_cnt", bus.bit_cnt, 8);

    // T3: continuous PRBS15 stopped after 1000 bits.
    cfg(3'd4, 0, 0);
    pulse_start();
    run_burst(1016);
    cnt = 0;
    for (int i = 17; i < 32; i++) cnt += int'(dat_log[i]);
    chk("t3_first15", cnt, 15);
    chk("t3_cnt_pre_stop", bus.bit_cnt, 1000);
    chk("t3_no_done", done_cyc, -1);
    bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
    chk("t3_stop_data", bus.data_out, 0);
    chk("t3_stop_done", bus.done, 1);
    chk("t3_stop_busy", bus.busy, 0);
    chk("t3_stop_cnt", bus.bit_cnt, 1000);

    // T4: START with STOP in idle is ignored; START while busy is ignored.
    cfg(3'd1, 5, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    run_burst(20);
    chk("t4_ss_busy", bus.busy, 0);
    chk("t4_ss_done", done_cyc, -1);
    chk("t4_ss_ones", ones, 0);
    cfg(3'd1, 40, 0);
    pulse_start();
    run_burst(30);
    cfg(3'd0, 3, 0);
    pulse_start();
    run_burst(40);
    chk("t4_restart_done", done_cyc, 26);
    chk("t4_restart_ones", ones, 25);
    chk("t4_restart_cnt", bus.bit_cnt, 40);

    // T5: delay clamps to MaxDly; reserved mode emits zeros.
    cfg(3'd1, 10, 100);
    pulse_start();
    run_burst(95);
    chk("t5_done_cyc", done_cyc, 27);
    chk("t5_ones", ones, 10);
    chk("t5_rpg_80", rpg_log[80], 0);
    chk("t5_rpg_81", rpg_log[81], 1);
    chk("t5_rpg_90", rpg_log[90], 1);
    chk("t5_rpg_91", rpg_log[91], 0);
    cfg(3'd6, 20, 3);
    pulse_start();
    run_burst(40);
    chk("t5_m6_done", done_cyc, 37);
    chk("t5_m6_ones", ones, 0);
    chk("t5_m6_cnt", bus.bit_cnt, 20);

    // T6: asynchronous reset mid-run, then T1 repeats.
    cfg(3'd3, 254, 0);
    pulse_start();
    run_burst(100);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_data", bus.data_out, 0);
    chk("t6_rst_rpg", bus.rpg_out, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_done", bus.done, 0);
    chk("t6_rst_cnt", bus.bit_cnt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    run_burst(280);
    chk("t6_done_cyc", done_cyc, 271);
    chk("t6_ones", ones, 128);
    chk("t6_cnt", bus.bit_cnt, 254);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
